// File: rtl/uart_rx_fifo_if.sv
// Pop-side bus of uart_rx_fifo: head byte, occupancy and pop strobe.
// The master drives rd_en. The slave (the receiver FIFO) drives the rest.
interface uart_rx_fifo_if #(
  parameter int unsigned CNT_W = 5
);
  logic             rd_en;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] fifo_count;

  modport master (output rd_en, input rd_data, input rd_valid, input fifo_count);
  modport slave  (input rd_en, output rd_data, output rd_valid, output fifo_count);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO, with sticky frame/overrun flags.
// Define UART_RX_PARITY_EN to add a parity bit (parity_odd input, sticky parity_err output).
module uart_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uart_rx,
  input  logic [31:0]   div,
  uart_rx_fifo_if.slave rd,
  output logic          frame_err,
  output logic          overrun,
  input  logic          clr_err
`ifdef UART_RX_PARITY_EN
  ,
  input  logic          parity_odd,
  output logic          parity_err
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state;
  logic        rx_meta, rx_s, rx_prev;
  logic [31:0] div_eff, div_lat, timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        expired, fall;
  logic        push, frame_set;
`ifdef UART_RX_PARITY_EN
  logic        par_bad, par_set;
`endif

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, pop, accept;

  always_comb begin
    div_eff = (div < 32'd4) ? 32'd4 : div;
    expired = (timer == '0);
    fall    = rx_prev & ~rx_s;
  end

  // Stop-bit decision is combinational so the byte lands in the FIFO on the sampling edge.
  always_comb begin
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set   = 1'b0;
`endif
    if (state == STOP && expired) begin
`ifdef UART_RX_PARITY_EN
      par_set = par_bad;
      push    = rx_s & ~par_bad;
`else
      push    = rx_s;
`endif
      frame_set = ~rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      timer     <= '0;
      div_lat   <= 32'd4;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      if (!expired) timer <= timer - 32'd1;
      case (state)
        IDLE: if (fall) begin
          div_lat <= div_eff;
          timer   <= (div_eff >> 1) - 32'd1;
          state   <= START;
        end
        START: if (expired) begin
          if (!rx_s) begin
            bit_idx <= '0;
            timer   <= div_lat - 32'd1;
            state   <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: if (expired) begin
          shift   <= {rx_s, shift[7:1]};
          bit_idx <= bit_idx + 3'd1;
          timer   <= div_lat - 32'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (expired) begin
          par_bad <= rx_s ^ (^shift) ^ parity_odd;
          timer   <= div_lat - 32'd1;
          state   <= STOP;
        end
`endif
        STOP: if (expired) state <= rx_s ? IDLE : WAIT_IDLE;
        WAIT_IDLE: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (par_set)      parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
`endif
    end
  end

  always_comb begin
    full   = (count == CNT_W'(FIFO_DEPTH));
    pop    = rd.rd_en && (count != '0);
    accept = push && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      if (accept && !pop)      count <= count + CNT_W'(1);
      else if (!accept && pop) count <= count - CNT_W'(1);
      if (push && full && !pop) overrun <= 1'b1;
      else if (clr_err)         overrun <= 1'b0;
    end
  end

  always_comb begin
    rd.rd_valid   = (count != '0);
    rd.rd_data    = rd.rd_valid ? mem[rd_ptr] : 8'h00;
    rd.fifo_count = count;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Asynchronous serial receiver feeding a first-word-fall-through byte FIFO.
- It is the receive counterpart of the SoC's uart_tx path. It lives inside attosoc on the clk domain and is driven from the top-level uart_rx pin.
- The SoC CPU sets the bit period through a divisor register and drains received bytes through a pop interface.
- Sticky error flags report framing errors and overruns.

Parameters:
- FIFO_DEPTH, 16, number of byte entries; must be a power of two, 2..256.
- CNT_W, 5, width of fifo_count; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock (133 MHz in the current build).
- reset  input  1  synchronous, active-high reset.
- uart_rx  input  1  asynchronous serial line; idle high.
- div  input  32  clk cycles per bit; values below 4 are treated as 4.
- rd_en  input  1  pop the head byte; ignored when rd_valid=0.
- rd_data  output  8  head byte of the FIFO; 8'h00 whenever rd_valid=0.
- rd_valid  output  1  FIFO not empty.
- fifo_count  output  CNT_W  number of bytes held.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte arrived while the FIFO was full.
- clr_err  input  1  clears frame_err and overrun.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset state:
  - FSM in IDLE.
  - FIFO empty: fifo_count=0, rd_valid=0, rd_data=8'h00.
  - frame_err=0, overrun=0.
  - Synchronizer flops preset to 1.
- Input path: uart_rx passes through a 2-flop synchronizer (rx_s). Falling-edge detect compares rx_s with its previous value.
- Bit timer: a 32-bit down-counter loaded with div_eff-1, where div_eff = max(div, 4). div is sampled once at start detection and held for the whole frame.
- FSM states:
  - IDLE: on a falling edge of rx_s, load the half-period (div_eff/2 - 1, rounded down) and go to START.
  - START: at timer expiry, if rx_s=0 go to DATA with bit index 0; otherwise this is a false start, return to IDLE with no side effects.
  - DATA: sample rx_s at each full-period expiry into the shift register, LSB first. After bit 7 go to STOP (or to PARITY when the optional feature is compiled in).
  - STOP: at expiry, if rx_s=1 push the byte; if rx_s=0 set frame_err, discard the byte and go to WAIT_IDLE. After a successful push, return to IDLE.
  - WAIT_IDLE: remain until rx_s=1, then go to IDLE. This prevents a break condition from producing repeated frames.
- Push latency: the byte appears at rd_data with rd_valid=1 on the cycle after the stop-bit sample, when the FIFO was empty.
- FIFO rules:
  - Pointers wrap modulo FIFO_DEPTH.
  - A push while full (fifo_count=FIFO_DEPTH) without a simultaneous pop drops the byte and sets overrun; stored contents are unchanged.
  - A simultaneous push and pop while full pops the head and accepts the new byte; fifo_count is unchanged and overrun is not set.
  - A simultaneous push and pop while empty pushes only, since rd_en is ignored; fifo_count becomes 1.
  - rd_en with rd_valid=1 advances the head, so the next byte is visible in the following cycle.
- Error flags:
  - clr_err clears frame_err and overrun.
  - If clr_err coincides with a new error event in the same cycle, the set wins.
- Reset mid-frame: the partial byte is discarded, the FIFO is emptied, the FSM returns to IDLE, and the flags clear. A falling edge in the synchronizer history at reset release must not start a frame; the flops are preset high.
- div changes mid-frame: these take effect at the next start bit only.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds input parity_odd (1 bit) and sticky output parity_err (1 bit, reset 0, cleared by clr_err).
  - A PARITY state follows DATA and samples one extra bit.
  - The expected value is the XOR of the 8 data bits, inverted when parity_odd=1.
  - On mismatch, parity_err is set and the byte is dropped after the stop bit is checked; a framing error is still flagged independently.
- When undefined: no PARITY state, no extra ports; the frame is 8N1 only.

Test Plan:
- Basic receive: div=16; send 8N1 byte 8'hA5 → rd_valid rises 1 cycle after the stop sample; rd_data=8'hA5; fifo_count=1. Then rd_en for 1 cycle → rd_valid=0 and rd_data=8'h00.
- Glitch rejection: div=16; drive uart_rx low for 5 cycles, then high → no push, FSM back in IDLE, frame_err=0.
- Framing error and break: div=16; send 8'h3C with stop bit low, hold the line low for 100 cycles, then idle; then send 8'h11 → frame_err=1, FIFO holds only 8'h11.
- Overrun: FIFO_DEPTH=16, div=8; send bytes 0x00..0x10 with no pops → fifo_count=16, overrun=1, and pops return 0x00..0x0F. Then clr_err → overrun=0.
- Push/pop collision at full: FIFO full; assert rd_en in the exact cycle of the 17th push → fifo_count stays 16, overrun=0, last entry=new byte.
- Reset mid-frame: assert reset during data bit 4 of 8'hFF, release, then send 8'h5A → only 8'h5A received. With UART_RX_PARITY_EN defined, parity_odd=0 and a wrong parity bit on 8'h07 → parity_err=1 and no push.
